// File: rtl/seq_count_param_sat.sv
// Parametrised up/down counter with configurable bounds, variable step,
// synchronous load/clear, runtime saturate-or-wrap, boundary decodes and a
// sticky flag recording any clip or wrap. Used as a confidence, credit or
// occupancy tracker. With WIDTH=2, RESET_VAL=2, step=1 and wrap=0 it behaves
// like the classic 2-bit saturating counter (op 00 = up, 01 = down).
module seq_count_param_sat #(
   parameter int WIDTH     = 4,
   parameter int STEP_W    = 2,
   parameter int MIN_VAL   = 0,
   parameter int MAX_VAL   = 2**WIDTH - 1,
   parameter int RESET_VAL = 2**(WIDTH - 1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              en,
   input  logic [1:0]        op,
   input  logic [STEP_W-1:0] step,
   input  logic [WIDTH-1:0]  load_val,
   input  logic              wrap,
   input  logic              sat_clr,
   output logic [WIDTH-1:0]  out,
   output logic              at_max,
   output logic              at_min,
   output logic              sat_flag
);

   // Two guard bits keep every intermediate sum, difference and bound
   // comparison free of truncation.
   localparam int AW = WIDTH + 2;

   localparam logic [AW-1:0]    MIN_A   = AW'(MIN_VAL);
   localparam logic [AW-1:0]    MAX_A   = AW'(MAX_VAL);
   localparam logic [AW-1:0]    RANGE_A = AW'(MAX_VAL - MIN_VAL + 1);
   localparam logic [AW-1:0]    ONE_A   = AW'(1);
   localparam logic [WIDTH-1:0] MIN_W   = WIDTH'(MIN_VAL);
   localparam logic [WIDTH-1:0] MAX_W   = WIDTH'(MAX_VAL);
   localparam logic [WIDTH-1:0] RST_W   = WIDTH'(RESET_VAL);

   typedef enum logic [1:0] {
      OP_INC   = 2'b00,
      OP_DEC   = 2'b01,
      OP_LOAD  = 2'b10,
      OP_CLEAR = 2'b11
   } op_e;

   op_e              op_sel;
   logic [WIDTH-1:0] count_q;
   logic             sat_q;
   logic [WIDTH-1:0] next_count;
   logic             hit;        // clip or wrap event this cycle

   logic [AW-1:0]    cur_a;
   logic [AW-1:0]    step_a;
   logic [AW-1:0]    load_a;
   logic [AW-1:0]    sum_a;
   logic [AW-1:0]    dec_lim_a;  // out - step < MIN  <=>  out < MIN + step
   logic [AW-1:0]    deficit_a;  // MIN - (out - step) - 1, valid only on underflow

   assign op_sel    = op_e'(op);
   assign cur_a     = {2'b00, count_q};
   assign step_a    = {{(AW-STEP_W){1'b0}}, step};
   assign load_a    = {2'b00, load_val};
   assign sum_a     = cur_a + step_a;
   assign dec_lim_a = MIN_A + step_a;
   assign deficit_a = dec_lim_a - cur_a - ONE_A;

   // Next-count and event decode for the selected operation.
   always_comb begin
      // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
      next_count = count_q;
      hit        = 1'b0;
      case (op_sel)
         OP_INC: begin
            if (sum_a > MAX_A) begin
               hit = 1'b1;
               if (wrap) next_count = WIDTH'(MIN_A + ((sum_a - MAX_A - ONE_A) % RANGE_A));
               else      next_count = MAX_W;
            end else begin
               next_count = WIDTH'(sum_a);
            end
         end
         OP_DEC: begin
            if (cur_a < dec_lim_a) begin
               hit = 1'b1;
               if (wrap) next_count = WIDTH'(MAX_A - (deficit_a % RANGE_A));
               else      next_count = MIN_W;
            end else begin
               next_count = WIDTH'(cur_a - step_a);
            end
         end
         OP_LOAD: begin
            if (load_a > MAX_A) begin
               next_count = MAX_W;
               hit        = 1'b1;
            end else if (load_a < MIN_A) begin
               next_count = MIN_W;
               hit        = 1'b1;
            end else begin
               next_count = load_val;
            end
         end
         OP_CLEAR: next_count = MIN_W;
      endcase
   end

   // Count and sticky-flag registers; an event outranks sat_clr.
   always_ff @(posedge clk or posedge reset) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (reset) begin
         count_q <= RST_W;
         sat_q   <= 1'b0;
      end else begin
         if (en) count_q <= next_count;
         if (en && hit)    sat_q <= 1'b1;
         else if (sat_clr) sat_q <= 1'b0;
      end
   end

   assign out      = count_q;
   assign sat_flag = sat_q;
   assign at_max   = (count_q == MAX_W);
   assign at_min   = (count_q == MIN_W);

endmodule

// File: doc/seq_count_param_sat.md
Name: seq_count_param_sat

Overview:
- Parametrised up/down counter; next generation of the fixed 2-bit binary saturating counter.
- Adds:
  - configurable width and bounds;
  - variable step;
  - synchronous load and clear;
  - runtime choice of saturate or wrap at the bounds;
  - boundary status flags and a sticky clip/wrap indicator.
- Used as a confidence, credit or occupancy tracker inside sequential control blocks.

Parameters:
- WIDTH, 4, counter width in bits (>= 2).
- STEP_W, 2, width of the step input (>= 1, <= WIDTH).
- MIN_VAL, 0, lower bound of the count.
- MAX_VAL, 2**WIDTH-1, upper bound of the count. Must satisfy MIN_VAL < MAX_VAL <= 2**WIDTH-1.
- RESET_VAL, 2**(WIDTH-1), value loaded on reset. Must satisfy MIN_VAL <= RESET_VAL <= MAX_VAL.

Ports:
- clk, input, 1, clock; all state updates on the rising edge.
- reset, input, 1, asynchronous, active-high reset.
- en, input, 1, update enable; when 0 all state holds.
- op, input, 2, operation: 00 inc, 01 dec, 10 load, 11 clear.
- step, input, STEP_W, magnitude for inc/dec.
- load_val, input, WIDTH, value used by the load op.
- wrap, input, 1, boundary mode: 0 saturate, 1 wrap.
- sat_clr, input, 1, clears sat_flag.
- out, output, WIDTH, current count.
- at_max, output, 1, out == MAX_VAL.
- at_min, output, 1, out == MIN_VAL.
- sat_flag, output, 1, sticky flag: a clip or wrap occurred.

Behaviour:
- Reset:
  - Asserting reset immediately forces out = RESET_VAL and sat_flag = 0, independent of clk.
  - at_max and at_min reflect RESET_VAL.
  - Reset overrides every other input, including mid-operation.
- Latency:
  - out and sat_flag are registers updated on posedge clk; new values are visible the cycle after the inputs are sampled.
  - at_max and at_min are pure decodes of the out register (no extra cycle).
- en = 0: out holds. sat_flag still honours sat_clr.
- Arithmetic: all intermediate arithmetic is done in WIDTH+2 bits unsigned, so no intermediate value truncates. RANGE = MAX_VAL - MIN_VAL + 1.
- inc (op = 00): sum = out + step.
  - sum <= MAX_VAL: next = sum.
  - sum > MAX_VAL, wrap = 0: next = MAX_VAL, clip event.
  - sum > MAX_VAL, wrap = 1: next = MIN_VAL + ((sum - MAX_VAL - 1) mod RANGE), wrap event.
- dec (op = 01): diff = out - step (signed view).
  - diff >= MIN_VAL: next = diff.
  - diff < MIN_VAL, wrap = 0: next = MIN_VAL, clip event.
  - diff < MIN_VAL, wrap = 1: next = MAX_VAL - ((MIN_VAL - diff - 1) mod RANGE), wrap event.
- step = 0 with inc or dec: out holds, no event.
- Inc already at MAX_VAL with saturate: out holds at MAX_VAL and this is still a clip event. The same applies to dec at MIN_VAL.
- load (op = 10):
  - next = load_val, clamped into [MIN_VAL, MAX_VAL].
  - A clamp is a clip event regardless of wrap.
- clear (op = 11): next = MIN_VAL, no event.
- sat_flag update, in priority order:
  1. Set on any clip or wrap event in an enabled cycle.
  2. Otherwise cleared by sat_clr.
  3. Otherwise holds.
  - An event and sat_clr in the same cycle leave sat_flag = 1.
- With WIDTH = 2, RESET_VAL = 2, step = 1, wrap = 0, and only inc/dec used, the block is cycle-identical to the 2-bit saturating counter (op 00 = up, 01 = down).

Test Plan:
- Reset and hold (defaults WIDTH = 4, MIN = 0, MAX = 15, RESET = 8):
  - Assert reset between clock edges -> out = 8 immediately, sat_flag = 0, at_max = at_min = 0.
  - Deassert, en = 0 for 3 cycles with op = inc -> out stays 8.
- Saturating up:
  - From 8, en = 1, op = inc, step = 3, wrap = 0 for 3 cycles -> out 11, 14, 15.
  - 3rd cycle sets sat_flag = 1 and at_max = 1.
  - One more inc -> out stays 15, sat_flag stays 1.
- Wrap down:
  - Clear (out = 0), sat_clr pulse (sat_flag = 0).
  - Then op = dec, step = 2, wrap = 1 -> out = 14, sat_flag = 1.
  - Next dec -> out = 12.
- Bounded instance (MIN = 3, MAX = 10, RESET = 5):
  - load load_val = 12 -> out = 10, sat_flag = 1.
  - load 1 -> out = 3, at_min = 1.
  - inc step = 3, wrap = 1 from 9 -> out = 4.
- Sticky priority:
  - From out = 15, saturate mode, inc with sat_clr = 1 in the same cycle -> sat_flag = 1.
  - Next cycle sat_clr = 1, op = clear -> sat_flag = 0, out = 0.
- Legacy equivalence: WIDTH = 2, RESET = 2, step = 1, random en/op(0/1) stream of 200 cycles -> out matches the 2-bit saturating counter model every cycle.
